// File: rtl/wallace_mac_pipe_pkg.sv
// Shared constants and the saturating accumulate step for the Wallace MAC pipeline.
// sat_add works on a fixed SAT_W-bit container so any accumulator up to SAT_W bits can use it.
package wallace_mac_pipe_pkg;

    localparam int N_DEF     = 16;
    localparam int ACC_W_DEF = 40;
    localparam int CNT_W_DEF = 8;
    localparam int SAT_W     = 64;

    // Returns {ovf, sum_sat}; sum_sat clamps to the all-ones value of an acc_w-bit accumulator.
    function automatic logic [SAT_W:0] sat_add(
        input logic [SAT_W-1:0] acc,
        input logic [SAT_W-1:0] p,
        input int unsigned      acc_w
    );
        logic [SAT_W:0]   sum;
        logic [SAT_W-1:0] max_val;
        logic             ovf;
        sum     = {1'b0, acc} + {1'b0, p};
        max_val = (acc_w >= SAT_W) ? '1 : ((SAT_W'(1) << acc_w) - SAT_W'(1));
        ovf     = sum[SAT_W] | (sum[SAT_W-1:0] > max_val);
        return ovf ? {1'b1, max_val} : {1'b0, sum[SAT_W-1:0]};
    endfunction

endpackage

// File: rtl/wallace_mac_pipe_wallace.sv
// Combinational unsigned NxN Wallace-tree multiplier: partial products are reduced with
// 3:2 carry-save compressors level by level until two rows remain, then one final add.
module wallace_mac_pipe_wallace #(
    parameter int N = 16
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] mul
);

    localparam int W = 2 * N;

    logic [W-1:0] rows [N];
    logic [W-1:0] nxt  [N];
    int           n_rows;
    int           m;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            rows[i] = b[i] ? (W'(a) << i) : '0;
        end
        n_rows = N;
        m      = 0;
        for (int lvl = 0; lvl < N; lvl++) begin
            if (n_rows > 2) begin
                for (int i = 0; i < N; i++) begin
                    nxt[i] = '0;
                end
                m = 0;
                // Every complete group of three rows becomes a sum row and a shifted carry row.
                for (int g = 0; g + 2 < N; g += 3) begin
                    if (g + 2 < n_rows) begin
                        nxt[m]     = rows[g] ^ rows[g+1] ^ rows[g+2];
                        nxt[m + 1] = ((rows[g] & rows[g+1]) | (rows[g] & rows[g+2]) |
                                      (rows[g+1] & rows[g+2])) << 1;
                        m = m + 2;
                    end
                end
                for (int r = 0; r < N; r++) begin
                    if (r >= (n_rows / 3) * 3 && r < n_rows) begin
                        nxt[m] = rows[r];
                        m = m + 1;
                    end
                end
                rows   = nxt;
                n_rows = m;
            end
        end
        mul = rows[0] + rows[1];
    end

endmodule

// File: rtl/wallace_mac_pipe.sv
// Multiply-accumulate stage: registers operand pairs, multiplies them with the Wallace tree,
// sums products over an in_last-delimited frame and emits one saturated result per frame.
module wallace_mac_pipe
    import wallace_mac_pipe_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    logic             v1_q, v1_d;
    logic [N-1:0]     a_q, a_d;
    logic [N-1:0]     b_q, b_d;
    logic             last_q, last_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_acc_q, ovf_acc_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             out_ovf_q, out_ovf_d;

    logic [2*N-1:0]   mul;
    logic [ACC_W-1:0] p;
    logic [SAT_W:0]   sat_res;
    logic [ACC_W-1:0] sum_sat;
    logic             ovf_beat;
    logic [CNT_W-1:0] cnt_next;
    logic             s1_stall;
    logic             s1_fire;
    logic             in_fire;
    logic [SAT_W-1-ACC_W:0] sat_unused;

    wallace_mac_pipe_wallace #(.N(N)) u_wallace (
        .a   (a_q),
        .b   (b_q),
        .mul (mul)
    );

    // Only a last beat facing a full, unaccepted output register holds S1.
    assign s1_stall  = v1_q & last_q & out_valid_q & ~out_ready;
    assign s1_fire   = v1_q & ~s1_stall;
    assign in_ready  = ~v1_q | s1_fire;
    assign in_fire   = in_valid & in_ready;

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

    always_comb begin
        p          = ACC_W'(mul);
        sat_res    = sat_add(SAT_W'(acc_q), SAT_W'(p), ACC_W);
        ovf_beat   = sat_res[SAT_W];
        sum_sat    = sat_res[ACC_W-1:0];
        sat_unused = sat_res[SAT_W-1:ACC_W];
        cnt_next   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    end

    always_comb begin
        v1_d        = v1_q;
        a_d         = a_q;
        b_d         = b_q;
        last_d      = last_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_acc_d   = ovf_acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        if (in_fire) begin
            v1_d   = 1'b1;
            a_d    = in_a;
            b_d    = in_b;
            last_d = in_last;
        end else if (s1_fire) begin
            v1_d = 1'b0;
        end

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (s1_fire) begin
            if (last_q) begin
                // A new result wins over the drain so results can flow back to back.
                out_valid_d = 1'b1;
                out_data_d  = sum_sat;
                out_count_d = cnt_next;
                out_ovf_d   = ovf_acc_q | ovf_beat;
                acc_d       = '0;
                cnt_d       = '0;
                ovf_acc_d   = 1'b0;
            end else begin
                acc_d     = sum_sat;
                cnt_d     = cnt_next;
                ovf_acc_d = ovf_acc_q | ovf_beat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q        <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            last_q      <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_acc_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            v1_q        <= v1_d;
            a_q         <= a_d;
            b_q         <= b_d;
            last_q      <= last_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_acc_q   <= ovf_acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

endmodule
